muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit with HI/LO result registers for the single-cycle MIPS core.
//   Operands come straight from the register-file read buses (busA = rs, busB = rt).
//   It executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles while the core stalls on busy.
//   HI/LO are readable at all times for MFHI/MFLO, and are writable by MTHI/MTLO.
// PARAMETERS
//   WIDTH   32   operand width; the algorithm runs one iteration per bit (WIDTH iterations)
// PORTS
//   clock   in   1        system clock; all state updates on rising edge
//   reset   in   1        asynchronous, active-low reset
//   start   in   1        request to begin an operation; sampled only in IDLE
//   op      in   2        00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//   a       in   WIDTH    rs operand: multiplicand / dividend
//   b       in   WIDTH    rt operand: multiplier / divisor
//   mthi    in   1        write a into hi; honoured only in IDLE
//   mtlo    in   1        write a into lo; honoured only in IDLE
//   busy    out  1        operation in progress; the core holds the PC while this is high
//   done    out  1        one-cycle pulse in the cycle where the new hi/lo are first visible
//   hi      out  WIDTH    HI register: product upper half / remainder
//   lo      out  WIDTH    LO register: product lower half / quotient
// BEHAVIOUR
//   Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
//     An operation in progress is aborted; no partial result is ever written to hi/lo.
//   States: IDLE -> CALC -> FIX -> IDLE.
//   IDLE
//     - start=1 at edge k: latch op and the result signs.
//     - Latch |a| and |b| (the raw values for unsigned ops); clear the accumulator; counter=0.
//     - Go to CALC; busy=1 from edge k.
//     - mthi/mtlo in the same cycle as start: ignored (start wins).
//     - mthi/mtlo without start: hi<=a and/or lo<=a at the edge (both if both high); no done pulse.
//   CALC: one iteration per edge, for edges k+1..k+WIDTH; counter increments; go to FIX after the last.
//     - Multiply: shift-add over the unsigned magnitudes into a 2*WIDTH-bit accumulator.
//     - Divide: restoring division producing one quotient bit per edge (MSB first).
//   FIX (edge k+WIDTH+1)
//     - Apply the sign correction and write hi/lo; busy<=0; done<=1 for exactly one cycle.
//     - Return to IDLE.
//     - Latency: start edge to done edge is WIDTH+1 edges (33 for WIDTH=32).
//     - A new start is accepted on the edge after FIX (back-to-back ops allowed).
//   Arithmetic rules
//     - Signed multiply: 2*WIDTH product, negated if sign(a)!=sign(b); hi=upper, lo=lower.
//     - Signed divide: quotient negated if the signs differ; remainder takes the sign of a (truncation).
//     - Divide by zero (DIV and DIVU): lo=all ones, hi=a (original value).
//       Same latency; no exception is raised.
//     - Signed overflow, 0x80000000 / -1: lo=0x80000000, hi=0.
//   Simultaneous and boundary events
//     - start, mthi or mtlo while busy (CALC/FIX): ignored; hi/lo hold their old values until FIX.
//     - a and b may change after the start edge without effect, because the operands are latched.
//     - done and busy never overlap; done=1 implies busy=0.
// TESTING
//   1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at start+33: hi=0xFFFFFFFE lo=0x00000001; busy was high for edges 1..32.
//   2. MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB.
//   3. DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3) hi=0xFFFFFFFF (-1).
//      DIVU a=100 b=7 -> lo=14 hi=2.
//   4. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF hi=0x1234.
//      DIV a=0x80000000 b=-1 -> lo=0x80000000 hi=0.
//   5. Start MULTU 5*6; pulse start (op=DIVU), then mthi (a=0xAAAA), at cycle 10 -> both ignored; done at 33 with hi=0 lo=30.
//      Then mtlo a=0x55 in IDLE -> lo=0x55, no done pulse.
//   6. Start DIVU, then drive reset=0 asynchronously mid-cycle at cycle 15 -> immediately busy=0, hi=lo=0, done never pulses.
//      After reset=1, a new MULTU 3*4 -> lo=12 at start+33.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
//   The core stalls on busy while MULT/MULTU/DIV/DIVU run over WIDTH+1 edges:
//   WIDTH iteration edges in CALC, then one sign-fix/write edge in FIX.
//   HI/LO can be read at any time and are written by MTHI/MTLO while idle.
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low
//   start        begin an operation (sampled only when idle)
//   op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         rs / rt operands (latched at start)
//   mthi, mtlo   write a into hi / lo while idle and not starting
//   busy         operation in progress
//   done         one-cycle pulse when new hi/lo first become visible
//   hi, lo       HI (product upper / remainder), LO (product lower / quotient)
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         state;
   logic               is_div;
   logic               neg_q;   // negate product / quotient
   logic               neg_r;   // negate remainder (signed divide with negative dividend)
   logic               divz;    // divisor was zero
   logic [WIDTH-1:0]   mb;      // |b| (raw b for unsigned ops)
   logic [2*WIDTH-1:0] acc;     // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
   logic [CW-1:0]      cnt;

   // Operand magnitudes and signs at start; unsigned ops have op[0]=1.
   logic             sa, sb;
   logic [WIDTH-1:0] abs_a, abs_b;
   assign sa    = a[WIDTH-1] & ~op[0];
   assign sb    = b[WIDTH-1] & ~op[0];
   assign abs_a = sa ? -a : a;
   assign abs_b = sb ? -b : b;

   // Multiply step: add multiplicand into the upper half when the LSB is set,
   // then shift the whole accumulator right (carry lands in the top bit).
   logic [WIDTH-1:0]   mb_sel;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mb_sel   = acc[0] ? mb : {WIDTH{1'b0}};
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mb_sel};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};

   // Restoring-divide step: shift the next dividend bit into the remainder
   // (needs WIDTH+1 bits), trial-subtract, keep the result if no borrow.
   logic [WIDTH:0]     rem_sh, diff;
   logic               qbit;
   logic [2*WIDTH-1:0] div_next;
   assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign diff     = rem_sh - {1'b0, mb};
   assign qbit     = ~diff[WIDTH];
   assign div_next = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], qbit};

   // Sign correction. For a zero divisor the remainder naturally ends up as |a|,
   // so restoring the dividend sign yields the original a; only lo needs forcing.
   // 0x80000000 / -1 falls out as quotient 0x80000000 (negation wraps), remainder 0.
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot, rem, q_fix, r_fix;
   assign prod  = neg_q ? -acc : acc;
   assign quot  = acc[WIDTH-1:0];
   assign rem   = acc[2*WIDTH-1:WIDTH];
   assign q_fix = divz ? {WIDTH{1'b1}} : (neg_q ? -quot : quot);
   assign r_fix = neg_r ? -rem : rem;

   assign busy = (state != S_IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         divz   <= 1'b0;
         mb     <= '0;
         acc    <= '0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  // start takes priority over a coincident mthi/mtlo
                  state  <= S_CALC;
                  is_div <= op[1];
                  neg_q  <= sa ^ sb;
                  neg_r  <= op[1] & sa;
                  divz   <= op[1] & (b == '0);
                  mb     <= abs_b;
                  acc    <= {{WIDTH{1'b0}}, abs_a};
                  cnt    <= '0;
               end else begin
                  if (mthi) hi <= a;
                  if (mtlo) lo <= a;
               end
            end
            S_CALC: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) state <= S_FIX;
            end
            S_FIX: begin
               if (is_div) begin
                  hi <= r_fix;
                  lo <= q_fix;
               end else begin
                  hi <= prod[2*WIDTH-1:WIDTH];
                  lo <= prod[WIDTH-1:0];
               end
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
